wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage of the multi-cycle MIPS core; sole driver of the reg_file write port.
//  Accepts one retiring instruction at a time: either an ALU/jal result, or a load awaiting memory read data.
//  Aligns and extends load data (LB/LBU/LH/LHU/LW/LWL/LWR, little-endian).
//  Issues exactly one reg_file write per instruction, then pulses done to the control FSM.
// PARAMETERS
//  DATA_WIDTH  32  datapath/register width
//  ADDR_WIDTH  5   register index width
// PORTS
//  clk              in   1   core clock; all state updates on posedge
//  rst              in   1   reset, asynchronous, active-high
//  in_valid         in   1   retiring instruction presented
//  in_ready         out  1   stage can accept (IDLE only)
//  in_is_load       in   1   1 = wait for mem_rdata; 0 = use in_result
//  in_load_op       in   3   0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 = LW
//  in_byte_off      in   2   effective address [1:0]
//  in_wen           in   1   instruction writes a register
//  in_dest          in   5   destination register index
//  in_result        in   32  ALU/link result (non-load)
//  in_old_rt        in   32  current rt value, merge source for LWL/LWR
//  mem_rdata_valid  in   1   memory read data valid
//  mem_rdata        in   32  memory read word
//  mem_rdata_ready  out  1   stage consumes mem_rdata (LOAD_WAIT only)
//  rf_wen           out  1   reg_file write enable
//  rf_waddr         out  5   reg_file write address
//  rf_wdata         out  32  reg_file write data
//  done             out  1   one-cycle retire pulse
// BEHAVIOUR
//  - Reset (async): state=IDLE; rf_wen=0, rf_waddr=0, rf_wdata=0, done=0; captured fields cleared.
//  - States: IDLE, LOAD_WAIT, WRITE (2-bit encoding).
//  - IDLE: in_ready=1. When in_valid=1, capture all in_* fields.
//    in_is_load=0 -> WRITE with wdata=in_result. in_is_load=1 -> LOAD_WAIT.
//  - LOAD_WAIT: in_ready=0, mem_rdata_ready=1. When mem_rdata_valid=1, register the aligned data -> WRITE.
//    Otherwise hold indefinitely; there is no timeout.
//  - WRITE: rf_wen = captured wen && dest!=0, and done=1, both for exactly this cycle; then -> IDLE.
//    in_ready=0 in WRITE, so back-to-back acceptance costs at least 2 cycles per instruction.
//  - Outputs rf_*/done are registered. mem_rdata_ready/in_ready are decoded from state only,
//    with no combinational path from inputs.
//  - Latency: non-load = 1 cycle from accept to rf_wen. Load = 1 cycle after the mem_rdata_valid handshake.
//  - rf_waddr/rf_wdata hold their last values outside WRITE. rf_wen=0 outside WRITE.
//  - dest==0 or wen=0: no write, but done still pulses.
//  - Alignment, with m=mem_rdata, o=in_old_rt, k=byte_off:
//    LB/LBU: byte k, sign/zero-extended.
//    LH/LHU: halfword k[1], sign/zero-extended; k[0] ignored.
//    LW/op7: m.
//    LWL: k=0 {m[7:0],o[23:0]}; k=1 {m[15:0],o[15:0]}; k=2 {m[23:0],o[7:0]}; k=3 m.
//    LWR: k=0 m; k=1 {o[31:24],m[31:8]}; k=2 {o[31:16],m[31:16]}; k=3 {o[31:8],m[31:24]}.
//  - mem_rdata_valid in IDLE/WRITE is ignored (ready=0); no data is captured.
//  - rst asserted mid-LOAD_WAIT or mid-WRITE: immediate return to IDLE; the pending write is dropped, no done.
//  - in_valid held across WRITE is not accepted until the following IDLE cycle.
// STRUCTURE
//  - Shared package/header: load-op codes (LOP_LB..LOP_LWR), state encodings, DATA_WIDTH/ADDR_WIDTH.
//  - Sub-module load_align: combinational (op, off, mem_rdata, old_rt) -> aligned word; instantiated once.
//  - Top: FSM, capture registers, output registers.
// TESTING
//  1. ALU write: accept {is_load=0, wen=1, dest=5, result=0xDEADBEEF}
//     -> next cycle rf_wen=1, waddr=5, wdata=0xDEADBEEF, done=1; in_ready=1 the cycle after.
//  2. LB sign: dest=8, off=2, mem=0x0080FF00, valid 3 cycles after accept
//     -> ready held 3 cycles; then rf_wdata=0xFFFFFF80, rf_wen=1. LBU same stimulus -> 0x00000080.
//  3. LWL/LWR merge: old=0x11223344, mem=0xAABBCCDD, off=1
//     -> LWL 0xCCDD3344, LWR 0x11AABBCC.
//  4. dest=0 ALU op with wen=1 -> rf_wen stays 0 and done=1 for one cycle.
//     Also: mem_rdata_valid pulsed in IDLE -> no state change.
//  5. Reset mid-load: accept load, assert rst for 1 cycle asynchronously before valid, then pulse valid
//     -> all outputs 0 immediately, no rf_wen, no done, in_ready=1 after rst is released.
//  6. Back-to-back: in_valid held high with 3 ALU ops
//     -> accepted every 2 cycles, 3 rf_wen pulses in order, no op dropped or duplicated.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load-op codes, FSM states and
// the captured-instruction record.
package wb_stage_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 5;

  localparam logic [2:0] LOP_LB  = 3'd0;
  localparam logic [2:0] LOP_LBU = 3'd1;
  localparam logic [2:0] LOP_LH  = 3'd2;
  localparam logic [2:0] LOP_LHU = 3'd3;
  localparam logic [2:0] LOP_LW  = 3'd4;
  localparam logic [2:0] LOP_LWL = 3'd5;
  localparam logic [2:0] LOP_LWR = 3'd6;
  localparam logic [2:0] LOP_LW7 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_WRITE     = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [2:0]               load_op;
    logic [1:0]               byte_off;
    logic                     wen;
    logic [WB_ADDR_WIDTH-1:0] dest;
    logic [WB_DATA_WIDTH-1:0] old_rt;
  } wb_req_t;

endpackage

// File: rtl/wb_stage_if.sv
// Retire/memory/reg_file bundle of the writeback stage. slave = the stage,
// master = whoever feeds it.
interface wb_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_is_load;
  logic [2:0]            in_load_op;
  logic [1:0]            in_byte_off;
  logic                  in_wen;
  logic [ADDR_WIDTH-1:0] in_dest;
  logic [DATA_WIDTH-1:0] in_result;
  logic [DATA_WIDTH-1:0] in_old_rt;
  logic                  mem_rdata_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rdata_ready;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  done;

  modport master (
    output in_valid, in_is_load, in_load_op, in_byte_off, in_wen, in_dest,
           in_result, in_old_rt, mem_rdata_valid, mem_rdata,
    input  in_ready, mem_rdata_ready, rf_wen, rf_waddr, rf_wdata, done
  );

  modport slave (
    input  in_valid, in_is_load, in_load_op, in_byte_off, in_wen, in_dest,
           in_result, in_old_rt, mem_rdata_valid, mem_rdata,
    output in_ready, mem_rdata_ready, rf_wen, rf_waddr, rf_wdata, done
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Little-endian load alignment: picks/extends the addressed byte or halfword,
// or merges memory with old rt for the unaligned LWL/LWR pair.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]               op,
  input  logic [1:0]               off,
  input  logic [WB_DATA_WIDTH-1:0] mem_rdata,
  input  logic [WB_DATA_WIDTH-1:0] old_rt,
  output logic [WB_DATA_WIDTH-1:0] aligned
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    aligned  = mem_rdata;
    case (op)
      LOP_LB:  aligned = {{24{byte_sel[7]}}, byte_sel};
      LOP_LBU: aligned = {24'd0, byte_sel};
      LOP_LH:  aligned = {{16{half_sel[15]}}, half_sel};
      LOP_LHU: aligned = {16'd0, half_sel};
      LOP_LWL: begin
        case (off)
          2'd0:    aligned = {mem_rdata[7:0],  old_rt[23:0]};
          2'd1:    aligned = {mem_rdata[15:0], old_rt[15:0]};
          2'd2:    aligned = {mem_rdata[23:0], old_rt[7:0]};
          default: aligned = mem_rdata;
        endcase
      end
      LOP_LWR: begin
        case (off)
          2'd1:    aligned = {old_rt[31:24], mem_rdata[31:8]};
          2'd2:    aligned = {old_rt[31:16], mem_rdata[31:16]};
          2'd3:    aligned = {old_rt[31:8],  mem_rdata[31:24]};
          default: aligned = mem_rdata;
        endcase
      end
      LOP_LW, LOP_LW7: aligned = mem_rdata;
      default:         aligned = mem_rdata;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts one retiring instruction, waits for load data if
// needed, then issues a single registered reg_file write plus a done pulse.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);
  wb_state_e             state_q, state_d;
  wb_req_t               req_q, req_d;
  logic                  rf_wen_q, rf_wen_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [DATA_WIDTH-1:0] aligned;

  wb_stage_load_align u_load_align (
    .op        (req_q.load_op),
    .off       (req_q.byte_off),
    .mem_rdata (bus.mem_rdata),
    .old_rt    (req_q.old_rt),
    .aligned   (aligned)
  );

  // rf_wen/done are loaded on the edge that enters WRITE, so they are high
  // for exactly the WRITE cycle and cleared on the way back to IDLE.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rf_wen_d   = 1'b0;
    done_d     = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          req_d.load_op  = bus.in_load_op;
          req_d.byte_off = bus.in_byte_off;
          req_d.wen      = bus.in_wen;
          req_d.dest     = bus.in_dest;
          req_d.old_rt   = bus.in_old_rt;
          if (bus.in_is_load) begin
            state_d = ST_LOAD_WAIT;
          end else begin
            state_d    = ST_WRITE;
            rf_wen_d   = bus.in_wen && (bus.in_dest != '0);
            done_d     = 1'b1;
            rf_waddr_d = bus.in_dest;
            rf_wdata_d = bus.in_result;
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (bus.mem_rdata_valid) begin
          state_d    = ST_WRITE;
          rf_wen_d   = req_q.wen && (req_q.dest != '0);
          done_d     = 1'b1;
          rf_waddr_d = req_q.dest;
          rf_wdata_d = aligned;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      rf_wen_q   <= 1'b0;
      done_q     <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rf_wen_q   <= rf_wen_d;
      done_q     <= done_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.in_ready        = (state_q == ST_IDLE);
  assign bus.mem_rdata_ready = (state_q == ST_LOAD_WAIT);
  assign bus.rf_wen          = rf_wen_q;
  assign bus.rf_waddr        = rf_waddr_q;
  assign bus.rf_wdata        = rf_wdata_q;
  assign bus.done            = done_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed steps plus randomized retire traffic checked
// against an arithmetic model of load alignment.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  wb_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Alignment from the byte-lane rules, using shifts and masks on whole words.
  function automatic logic [31:0] model(input int op, input int k, input logic [31:0] m,
                                        input logic [31:0] o);
    logic [31:0] b, h;
    b = (m >> (8 * k)) & 32'hFF;
    h = (m >> (16 * (k / 2))) & 32'hFFFF;
    case (op)
      0:       return (b >= 32'd128)   ? b - 32'd256     : b;
      1:       return b;
      2:       return (h >= 32'd32768) ? h - 32'h10000   : h;
      3:       return h;
      5:       return (m << (8 * (3 - k))) | (o & ((32'd1 << (8 * (3 - k))) - 32'd1));
      6:       return (m >> (8 * k)) | (o & ~(32'hFFFFFFFF >> (8 * k)));
      default: return m;
    endcase
  endfunction

  task automatic idle_bus();
    bus.in_valid = 1'b0; bus.in_is_load = 1'b0; bus.in_load_op = 3'd0;
    bus.in_byte_off = 2'd0; bus.in_wen = 1'b0; bus.in_dest = 5'd0;
    bus.in_result = 32'd0; bus.in_old_rt = 32'd0;
    bus.mem_rdata_valid = 1'b0; bus.mem_rdata = 32'd0;
  endtask

  // Both run_* tasks start and end at a negedge with the DUT idle.
  task automatic run_alu(input logic [4:0] dest, input logic wen, input logic [31:0] res);
    logic exp_wen;
    exp_wen = wen && (dest != 5'd0);
    check("alu_accept_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.in_is_load = 1'b0; bus.in_wen = wen; bus.in_dest = dest;
    bus.in_result = res; bus.in_load_op = 3'($urandom); bus.in_old_rt = $urandom;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("alu_rf_wen", bus.rf_wen, exp_wen);
    check("alu_done", bus.done, 1'b1);
    check("alu_busy", bus.in_ready, 1'b0);
    if (exp_wen) begin
      check("alu_waddr", bus.rf_waddr, dest);
      check("alu_wdata", bus.rf_wdata, res);
    end
    @(negedge clk);
    check("alu_done_clr", bus.done, 1'b0);
    check("alu_wen_clr", bus.rf_wen, 1'b0);
    check("alu_ready_again", bus.in_ready, 1'b1);
  endtask

  task automatic run_load(input int op, input int off, input logic [4:0] dest, input logic wen,
                          input logic [31:0] old, input logic [31:0] mem, input int delay);
    logic exp_wen;
    exp_wen = wen && (dest != 5'd0);
    check("ld_accept_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_load_op = 3'(op);
    bus.in_byte_off = 2'(off); bus.in_wen = wen; bus.in_dest = dest;
    bus.in_old_rt = old; bus.in_result = $urandom;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_old_rt = $urandom; bus.mem_rdata = $urandom;
    for (int i = 0; i < delay; i++) begin
      check("ld_wait_mready", bus.mem_rdata_ready, 1'b1);
      check("ld_wait_busy", bus.in_ready, 1'b0);
      check("ld_wait_nowen", bus.rf_wen | bus.done, 1'b0);
      @(negedge clk);
    end
    check("ld_mready", bus.mem_rdata_ready, 1'b1);
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = mem;
    @(negedge clk);
    bus.mem_rdata_valid = 1'b0; bus.mem_rdata = $urandom;
    check("ld_rf_wen", bus.rf_wen, exp_wen);
    check("ld_done", bus.done, 1'b1);
    check("ld_mready_clr", bus.mem_rdata_ready, 1'b0);
    if (exp_wen) begin
      check("ld_waddr", bus.rf_waddr, dest);
      check("ld_wdata", bus.rf_wdata, model(op, off, mem, old));
    end
    @(negedge clk);
    check("ld_done_clr", bus.done | bus.rf_wen, 1'b0);
    check("ld_ready_again", bus.in_ready, 1'b1);
  endtask

  logic [4:0]  b2b_dest [3];
  logic [31:0] b2b_data [3];
  int          seen_cyc [$];
  logic [4:0]  seen_dest[$];
  logic [31:0] seen_data[$];

  initial begin
    int  k;
    logic ready_now;
    idle_bus();
    rst = 1'b1;
    #1;
    check("rst_wen", bus.rf_wen, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_waddr", bus.rf_waddr, 5'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_mready", bus.mem_rdata_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", bus.in_ready, 1'b1);

    // ALU write
    run_alu(5'd5, 1'b1, 32'hDEADBEEF);
    check("t1_wdata_hold", bus.rf_wdata, 32'hDEADBEEF);

    // LB / LBU from byte 2 with three wait cycles
    run_load(0, 2, 5'd8, 1'b1, 32'h0, 32'h0080FF00, 3);
    check("t2_lb", bus.rf_wdata, 32'hFFFFFF80);
    run_load(1, 2, 5'd8, 1'b1, 32'h0, 32'h0080FF00, 3);
    check("t2_lbu", bus.rf_wdata, 32'h00000080);

    // LWL / LWR merge
    run_load(5, 1, 5'd3, 1'b1, 32'h11223344, 32'hAABBCCDD, 0);
    check("t3_lwl", bus.rf_wdata, 32'hCCDD3344);
    run_load(6, 1, 5'd3, 1'b1, 32'h11223344, 32'hAABBCCDD, 1);
    check("t3_lwr", bus.rf_wdata, 32'h11AABBCC);

    // Reset while waiting for load data
    run_alu(5'd9, 1'b1, 32'h12345678);
    check("t5_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_load_op = 3'd4;
    bus.in_wen = 1'b1; bus.in_dest = 5'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t5_in_wait", bus.mem_rdata_ready, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_wen", bus.rf_wen, 1'b0);
    check("t5_rst_done", bus.done, 1'b0);
    check("t5_rst_waddr", bus.rf_waddr, 5'd0);
    check("t5_rst_wdata", bus.rf_wdata, 32'd0);
    check("t5_rst_mready", bus.mem_rdata_ready, 1'b0);
    #9 rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after", bus.in_ready, 1'b1);
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.mem_rdata_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("t5_no_write", bus.rf_wen | bus.done, 1'b0);
      check("t5_idle", bus.in_ready, 1'b1);
      @(negedge clk);
    end

    // dest 0 write, then stray memory valid in IDLE
    run_alu(5'd0, 1'b1, 32'h0BADF00D);
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    bus.mem_rdata_valid = 1'b0;
    check("t4_stray_ready", bus.in_ready, 1'b1);
    check("t4_stray_mready", bus.mem_rdata_ready, 1'b0);
    check("t4_stray_nowr", bus.rf_wen | bus.done, 1'b0);

    // Back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin
      b2b_dest[i] = 5'(11 + i);
      b2b_data[i] = $urandom;
    end
    k = 0;
    bus.in_valid = 1'b1; bus.in_is_load = 1'b0; bus.in_wen = 1'b1;
    bus.in_dest = b2b_dest[0]; bus.in_result = b2b_data[0];
    for (int c = 0; c < 10; c++) begin
      ready_now = bus.in_ready;
      @(negedge clk);
      if (bus.rf_wen) begin
        seen_cyc.push_back(c);
        seen_dest.push_back(bus.rf_waddr);
        seen_data.push_back(bus.rf_wdata);
      end
      if (ready_now && bus.in_valid) begin
        k++;
        if (k < 3) begin
          bus.in_dest = b2b_dest[k]; bus.in_result = b2b_data[k];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check("t6_count", seen_cyc.size(), 3);
    for (int i = 0; i < 3 && i < seen_cyc.size(); i++) begin
      check("t6_cycle", seen_cyc[i], 2 * i);
      check("t6_dest", seen_dest[i], b2b_dest[i]);
      check("t6_data", seen_data[i], b2b_data[i]);
    end

    // Randomized retire traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0)
        run_alu(5'($urandom), 1'($urandom_range(0, 3) != 0), $urandom);
      else
        run_load($urandom_range(0, 7), $urandom_range(0, 3), 5'($urandom),
                 1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
